// File: rtl/swan64_word_loader.sv
// swan64_word_loader
// Collects a 6-word frame (4 key words, 2 block words) from a 32-bit
// valid/ready stream, launches a SWAN64K128 encryption or decryption core
// with a one-cycle start pulse, captures the 64-bit result and returns it
// as two 32-bit words on a downstream valid/ready stream.
// Optional feature macro: SWAN_LOADER_TIMEOUT_EN adds a sticky err output
// and an 8-bit watchdog that abandons a core run after 255 WAIT cycles.
// Key and block buses use ascending bit numbering: index 0 is the MSB.
module swan64_word_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    output logic         core_start,
    output logic [0:127] core_key,
    output logic [0:63]  core_inp,
    input  logic         core_ready,
    input  logic [0:63]  core_out,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data
`ifdef SWAN_LOADER_TIMEOUT_EN
    ,
    output logic         err
`endif
);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        OUT0  = 3'd3,
        OUT1  = 3'd4
    } state_t;

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [0:63] result_r;
`ifdef SWAN_LOADER_TIMEOUT_EN
    logic [7:0]  tcnt_r;
`endif

    // Frame FSM: all handshake, core-control and output registers advance here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= LOAD;
            cnt_r      <= 3'd0;
            s_ready    <= 1'b0;
            core_start <= 1'b0;
            core_key   <= 128'd0;
            core_inp   <= 64'd0;
            result_r   <= 64'd0;
            m_valid    <= 1'b0;
            m_data     <= 32'd0;
`ifdef SWAN_LOADER_TIMEOUT_EN
            tcnt_r     <= 8'd0;
            err        <= 1'b0;
`endif
        end else begin
            case (state_r)
                LOAD: begin
                    if (s_valid && s_ready) begin
                        case (cnt_r)
                            3'd0:    core_key[0:31]   <= s_data;
                            3'd1:    core_key[32:63]  <= s_data;
                            3'd2:    core_key[64:95]  <= s_data;
                            3'd3:    core_key[96:127] <= s_data;
                            3'd4:    core_inp[0:31]   <= s_data;
                            3'd5:    core_inp[32:63]  <= s_data;
                            default: core_inp         <= core_inp;
                        endcase
                        if (cnt_r == 3'd5) begin
                            // Last word: close the frame and start the core next cycle.
                            cnt_r      <= 3'd0;
                            s_ready    <= 1'b0;
                            core_start <= 1'b1;
                            state_r    <= START;
                        end else begin
                            cnt_r   <= cnt_r + 3'd1;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    state_r    <= WAIT;
`ifdef SWAN_LOADER_TIMEOUT_EN
                    tcnt_r     <= 8'd0;
`endif
                end
                WAIT: begin
                    if (core_ready) begin
                        // First result word goes straight out so m_valid rises next cycle.
                        result_r <= core_out;
                        m_data   <= core_out[0:31];
                        m_valid  <= 1'b1;
                        state_r  <= OUT0;
                    end else begin
`ifdef SWAN_LOADER_TIMEOUT_EN
                        if (tcnt_r == 8'd254) begin
                            // 255th silent cycle: give up on this frame.
                            err     <= 1'b1;
                            tcnt_r  <= 8'd0;
                            s_ready <= 1'b1;
                            state_r <= LOAD;
                        end else begin
                            tcnt_r <= tcnt_r + 8'd1;
                        end
`else
                        state_r <= WAIT;
`endif
                    end
                end
                OUT0: begin
                    if (m_ready) begin
                        m_data  <= result_r[32:63];
                        state_r <= OUT1;
                    end else begin
                        m_data <= result_r[0:31];
                    end
                end
                OUT1: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        m_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= LOAD;
                    cnt_r      <= 3'd0;
                    s_ready    <= 1'b0;
                    core_start <= 1'b0;
                    m_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_swan64_word_loader.sv
// Directed self-checking bench for swan64_word_loader. The bench plays the
// role of the SWAN64K128 core: it checks the key/block it is handed and
// answers with the reference result for that vector.
module tb_swan64_word_loader;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         core_start;
    logic [0:127] core_key;
    logic [0:63]  core_inp;
    logic         core_ready;
    logic [0:63]  core_out;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
`ifdef SWAN_LOADER_TIMEOUT_EN
    logic         err;
`endif

    int errors = 0;
    int checks = 0;

    swan64_word_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .core_start (core_start),
        .core_key   (core_key),
        .core_inp   (core_inp),
        .core_ready (core_ready),
        .core_out   (core_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef SWAN_LOADER_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word at a negedge and hold it until the handshake edge has passed.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("s_ready_timeout", 128'd0, 128'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] k0, input logic [31:0] k1,
                             input logic [31:0] k2, input logic [31:0] k3,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [63:0] res, input int stall);
        logic [31:0] w [6];
        w[0] = k0; w[1] = k1; w[2] = k2; w[3] = k3; w[4] = d0; w[5] = d1;
        for (int i = 0; i < 6; i++) send_word(w[i]);
        // One cycle after the word-5 handshake.
        check("core_start_rise", {127'd0, core_start}, 128'd1);
        check("s_ready_start", {127'd0, s_ready}, 128'd0);
        @(negedge clk);
        check("core_start_one_cycle", {127'd0, core_start}, 128'd0);
        check("core_key", core_key, {k0, k1, k2, k3});
        check("core_inp", {64'd0, core_inp}, {64'd0, d0, d1});
        repeat (3) @(negedge clk);
        check("m_valid_wait", {127'd0, m_valid}, 128'd0);
        check("s_ready_wait", {127'd0, s_ready}, 128'd0);
        check("core_key_hold", core_key, {k0, k1, k2, k3});
        core_ready = 1'b1;
        core_out   = res;
        @(negedge clk);
        core_ready = 1'b0;
        core_out   = ~res;
        check("m_valid_out0", {127'd0, m_valid}, 128'd1);
        check("m_data_word0", {96'd0, m_data}, {96'd0, res[63:32]});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("m_data_stall", {96'd0, m_data}, {96'd0, res[63:32]});
            check("m_valid_stall", {127'd0, m_valid}, 128'd1);
            check("s_ready_stall", {127'd0, s_ready}, 128'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("m_valid_out1", {127'd0, m_valid}, 128'd1);
        check("m_data_word1", {96'd0, m_data}, {96'd0, res[31:0]});
        @(negedge clk);
        m_ready = 1'b0;
        check("m_valid_done", {127'd0, m_valid}, 128'd0);
        check("s_ready_done", {127'd0, s_ready}, 128'd1);
    endtask

    initial begin
        rst        = 1'b0;
        s_valid    = 1'b0;
        s_data     = 32'd0;
        core_ready = 1'b0;
        core_out   = 64'd0;
        m_ready    = 1'b0;
        #1;
        // Reset state.
        check("rst_s_ready", {127'd0, s_ready}, 128'd0);
        check("rst_core_start", {127'd0, core_start}, 128'd0);
        check("rst_core_key", core_key, 128'd0);
        check("rst_core_inp", {64'd0, core_inp}, 128'd0);
        check("rst_m_valid", {127'd0, m_valid}, 128'd0);
        check("rst_m_data", {96'd0, m_data}, 128'd0);
`ifdef SWAN_LOADER_TIMEOUT_EN
        check("rst_err", {127'd0, err}, 128'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst", {127'd0, s_ready}, 128'd1);

        // Stray core_ready while loading must be ignored.
        core_ready = 1'b1;
        core_out   = 64'hdeadbeef_cafef00d;
        @(negedge clk);
        core_ready = 1'b0;
        check("stray_core_ready", {127'd0, m_valid}, 128'd0);

        // Encryption vector 1.
        run_frame(32'h0, 32'h0, 32'h0, 32'h0, 32'h88776655, 32'h44332211,
                  64'h94db436f_ab46b0ca, 0);
        // Encryption vector 2 with a 10-cycle downstream stall.
        run_frame(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                  32'hf0debc9a, 32'h78563412, 64'h9728ec40_1eb2271e, 10);
        // Decryption vector.
        run_frame(32'h78563412, 32'h78563412, 32'h78563412, 32'h78563412,
                  32'hb933b6ea, 32'h2bc9455d, 64'hefcdab90_78563412, 0);

        // Reset after three words of a frame.
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        rst = 1'b0;
        #1;
        check("midrst_core_key", core_key, 128'd0);
        check("midrst_s_ready", {127'd0, s_ready}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_ready_back", {127'd0, s_ready}, 128'd1);
        check("midrst_m_valid", {127'd0, m_valid}, 128'd0);
        run_frame(32'h0, 32'h0, 32'h0, 32'h0, 32'h88776655, 32'h44332211,
                  64'h94db436f_ab46b0ca, 0);

`ifdef SWAN_LOADER_TIMEOUT_EN
        check("err_clear", {127'd0, err}, 128'd0);
        // Core never answers: watchdog must fire 255 cycles into WAIT.
        send_word(32'h0); send_word(32'h0); send_word(32'h0);
        send_word(32'h0); send_word(32'h0); send_word(32'h0);
        check("to_core_start", {127'd0, core_start}, 128'd1);
        repeat (255) @(negedge clk);
        check("to_err_not_yet", {127'd0, err}, 128'd0);
        @(negedge clk);
        check("to_err_set", {127'd0, err}, 128'd1);
        check("to_m_valid", {127'd0, m_valid}, 128'd0);
        check("to_s_ready", {127'd0, s_ready}, 128'd1);
        repeat (3) @(negedge clk);
        check("to_err_sticky", {127'd0, err}, 128'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/swan64_word_loader.md
SWAN64_WORD_LOADER -- requirements
Module: swan64_word_loader

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have s_valid, input, 1, upstream word valid.
REQ-004 SHALL have s_ready, output, 1, upstream word accepted when s_valid && s_ready.
REQ-005 SHALL have s_data, input, 32, upstream word.
REQ-006 SHALL have core_start, output, 1, start pulse to SWAN64K128_ENC or SWAN64K128_DEC.
REQ-007 SHALL have core_key, output, 128 (bits [0:127]), key to core.
REQ-008 SHALL have core_inp, output, 64 (bits [0:63]), block to core.
REQ-009 SHALL have core_ready, input, 1, core done strobe.
REQ-010 SHALL have core_out, input, 64 (bits [0:63]), core result.
REQ-011 SHALL have m_valid, output, 1, downstream word valid.
REQ-012 SHALL have m_ready, input, 1, downstream accepts when m_valid && m_ready.
REQ-013 SHALL have m_data, output, 32, downstream word.
REQ-014 SHALL have err, output, 1, sticky timeout flag (present only with SWAN_LOADER_TIMEOUT_EN).

Function
REQ-015 SHALL process frames of 6 input words: words 0-3 form the key, words 4-5 form the block.
REQ-016 SHALL place word k (k=0..3) into core_key[32k:32k+31]; word 4 into core_inp[0:31]; word 5 into core_inp[32:63].
REQ-017 SHALL use FSM states LOAD, START, WAIT, OUT0, OUT1.
REQ-018 SHALL, in LOAD, assert s_ready and advance a 3-bit word counter on each accepted word; on acceptance of word 5, go to START and clear the counter.
REQ-019 SHALL, in START, assert core_start for exactly one cycle, then go to WAIT.
REQ-020 SHALL hold core_key and core_inp stable from START until the core_ready strobe.
REQ-021 SHALL, in WAIT, ignore s_valid, keep s_ready low, and on core_ready capture core_out into a 64-bit result register and go to OUT0.
REQ-022 SHALL, in OUT0, drive m_valid=1 with m_data=result[0:31]; on handshake go to OUT1.
REQ-023 SHALL, in OUT1, drive m_valid=1 with m_data=result[32:63]; on handshake go to LOAD.
REQ-024 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-025 SHALL deassert s_ready in every state except LOAD; pipelining of the next frame is not supported.
REQ-026 SHALL ignore a core_ready seen outside WAIT.
REQ-027 SHALL have a latency from the word-5 handshake to core_start of exactly 1 cycle.
REQ-028 SHALL present m_valid in the cycle after core_ready is sampled.

Reset
REQ-029 SHALL, on rst low, immediately force: state LOAD, counter 0, s_ready 0, core_start 0, core_key 0, core_inp 0, result 0, m_valid 0, m_data 0, err 0.
REQ-030 SHALL assert s_ready in the first cycle after rst deasserts.
REQ-031 SHALL abandon any partial frame or pending result when rst is asserted mid-operation; it SHALL not emit a stale output after reset.

Configuration
REQ-032 SHALL, with SWAN_LOADER_TIMEOUT_EN defined, run an 8-bit counter in WAIT; if core_ready has not arrived after 255 cycles, it SHALL set err (sticky until reset), emit no output, and return to LOAD.
REQ-033 SHALL, without SWAN_LOADER_TIMEOUT_EN, have no err port and no counter, and SHALL wait indefinitely in WAIT.

Verification
REQ-034 SHALL test the encryption core with the 6-word stream 00000000 x4, 88776655, 44332211 -> m_data 94db436f then ab46b0ca.
REQ-035 SHALL test the encryption core with the stream ffffffff x4, f0debc9a, 78563412 -> m_data 9728ec40 then 1eb2271e; core_start shall be high for 1 cycle only.
REQ-036 SHALL test the decryption core with key 78563412 x4 and data b933b6ea, 2bc9455d -> m_data efcdab90 then 78563412.
REQ-037 SHALL hold m_ready=0 for 10 cycles after m_valid rises; m_data shall stay stable, s_ready shall stay 0, and both words shall then complete in order.
REQ-038 SHALL assert rst after 3 words of a frame are accepted; after release, a full 6-word frame with test vector 1 shall produce 94db436f and ab46b0ca.
REQ-039 SHALL, with SWAN_LOADER_TIMEOUT_EN and core_ready tied low, set err 255 cycles after WAIT is entered, keep m_valid at 0, and raise s_ready again.
